// File: rtl/mbldcm_pkg.sv
// Shared types and constants for the BLDC commutation controller.
//   mbldcmState_t : sequencer states (IDLE / RUN / STOPPING)
//   pFreqW        : width of step-period values in clocks
//   pPhaseCount   : number of commutation phases (six-step)
//   clampTarget() : maps a host period request onto the legal range
package mbldcm_pkg;

  localparam int pFreqW      = 32;
  localparam int pPhaseCount = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } mbldcmState_t;

  // 0 stays 0 (stop request); otherwise limit to [minP, startP].
  function automatic logic [pFreqW-1:0] clampTarget(
    input logic [pFreqW-1:0] v,
    input logic [pFreqW-1:0] minP,
    input logic [pFreqW-1:0] startP
  );
    logic [pFreqW-1:0] r;
    if (v == '0)         r = '0;
    else if (v < minP)   r = minP;
    else if (v > startP) r = startP;
    else                 r = v;
    return r;
  endfunction

endpackage

// File: rtl/mbldcm_commutation_ctrl_if.sv
// Host-side bundle of the commutation controller: target/phase writes from
// the register block, run enable, and phase/status outputs.
//   master : register interface / test driver
//   slave  : mbldcm_commutation_ctrl
interface mbldcm_commutation_ctrl_if;
  import mbldcm_pkg::*;

  logic [pFreqW-1:0] iFreqTarget;
  logic              iLatchFreqTarget;
  logic [pFreqW-1:0] oFreqTarget;
  logic [2:0]        iPhaseUpdate;
  logic              iLatchPhaseUpdate;
  logic              iEnable;
  logic [2:0]        oPhase;
  logic              oPhaseStep;
  logic              oFreqReflected;
  logic              oStop;

  modport master (
    output iFreqTarget, iLatchFreqTarget, iPhaseUpdate, iLatchPhaseUpdate, iEnable,
    input  oFreqTarget, oPhase, oPhaseStep, oFreqReflected, oStop
  );

  modport slave (
    input  iFreqTarget, iLatchFreqTarget, iPhaseUpdate, iLatchPhaseUpdate, iEnable,
    output oFreqTarget, oPhase, oPhaseStep, oFreqReflected, oStop
  );

endinterface

// File: rtl/mbldcm_ramp_gen.sv
// Live step-period generator. Every pRampDiv active clocks it moves the live
// period by pRampStep, either toward iTarget (saturating at it) or up toward
// pStartPeriod (spin-down). Arithmetic is one bit wider than the period so
// sums never wrap.
//   iClock, iReset_n : clock, async active-low reset
//   iClear           : zero live period and tick counter (coast / idle)
//   iLoad            : load iLoadVal, restart tick counter (spin-up)
//   iActive          : ramp counter runs
//   iTowardStart     : 1 = ramp up to pStartPeriod, 0 = ramp toward iTarget
//   iTarget          : registered target period
//   oLive            : live step period
module mbldcm_ramp_gen
  import mbldcm_pkg::*;
#(
  parameter logic [pFreqW-1:0] pStartPeriod = 32'd1000000,
  parameter logic [pFreqW-1:0] pRampStep    = 32'd100,
  parameter logic [15:0]       pRampDiv     = 16'd1000
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic              iLoad,
  input  logic              iActive,
  input  logic              iTowardStart,
  input  logic [pFreqW-1:0] iTarget,
  input  logic [pFreqW-1:0] iLoadVal,
  output logic [pFreqW:0]   oLive
);

  localparam logic [pFreqW:0] cStart = {1'b0, pStartPeriod};
  localparam logic [pFreqW:0] cStep  = {1'b0, pRampStep};

  logic [15:0]     rampCnt;
  logic            rampTick;
  logic [pFreqW:0] target, up, down, nextLive;

  assign rampTick = (rampCnt == pRampDiv - 16'd1);

  always_comb begin
    target   = {1'b0, iTarget};
    up       = oLive + cStep;
    down     = (oLive > cStep) ? oLive - cStep : '0;
    nextLive = oLive;
    if (iTowardStart)        nextLive = (up > cStart) ? cStart : up;
    else if (oLive < target) nextLive = (up > target) ? target : up;
    else if (oLive > target) nextLive = (down < target) ? target : down;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      rampCnt <= '0;
      oLive   <= '0;
    end else if (iClear) begin
      rampCnt <= '0;
      oLive   <= '0;
    end else if (iLoad) begin
      rampCnt <= '0;
      oLive   <= {1'b0, iLoadVal};
    end else if (iActive) begin
      rampCnt <= rampTick ? '0 : rampCnt + 16'd1;
      if (rampTick) oLive <= nextLive;
    end
  end

endmodule

// File: rtl/mbldcm_commutation_ctrl.sv
// Six-step BLDC commutation sequencer. Holds the clamped host target period,
// ramps a live period toward it, advances the commutation phase each live
// period, accepts host phase overrides and reports Stop/FreqReflected.
//   iClock, iReset_n : clock, async active-low reset
//   host (slave)     : target write/readback, phase override, enable,
//                      phase, step pulse and status outputs
module mbldcm_commutation_ctrl
  import mbldcm_pkg::*;
#(
  parameter logic [pFreqW-1:0] pStartPeriod = 32'd1000000,
  parameter logic [pFreqW-1:0] pMinPeriod   = 32'd1000,
  parameter logic [pFreqW-1:0] pRampStep    = 32'd100,
  parameter logic [15:0]       pRampDiv     = 16'd1000
) (
  input  logic                      iClock,
  input  logic                      iReset_n,
  mbldcm_commutation_ctrl_if.slave  host
);

  localparam logic [pFreqW:0] cStart     = {1'b0, pStartPeriod};
  localparam logic [2:0]      cLastPhase = 3'(pPhaseCount - 1);

  mbldcmState_t      state, nextState;
  logic [pFreqW-1:0] freqTarget, stepCnt;
  logic [pFreqW:0]   live;
  logic [2:0]        phase;
  logic              phaseStep, freqReflected, stop;
  logic              running, spinUp, rampClear, towardStart, stepDue, phaseLoad;

  // ---- target register ----
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n)                  freqTarget <= '0;
    else if (host.iLatchFreqTarget) freqTarget <= clampTarget(host.iFreqTarget, pMinPeriod, pStartPeriod);
  end

  // ---- sequencer FSM ----
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) state <= IDLE;
    else           state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (freqTarget != '0) nextState = RUN;
      RUN:      if (freqTarget == '0) nextState = STOPPING;
      STOPPING: if (freqTarget != '0)  nextState = RUN;
                else if (live >= cStart) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
    // Dropping enable coasts from any state.
    if (!host.iEnable) nextState = IDLE;
  end

  assign running     = (state != IDLE) && host.iEnable;
  assign spinUp      = (state == IDLE) && (nextState == RUN);
  assign rampClear   = (nextState == IDLE);
  assign towardStart = (state == STOPPING);

  mbldcm_ramp_gen #(
    .pStartPeriod(pStartPeriod),
    .pRampStep   (pRampStep),
    .pRampDiv    (pRampDiv)
  ) uRamp (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iClear      (rampClear),
    .iLoad       (spinUp),
    .iActive     (running),
    .iTowardStart(towardStart),
    .iTarget     (freqTarget),
    .iLoadVal    (pStartPeriod),
    .oLive       (live)
  );

  // ---- step counter and phase ----
  // cnt >= live-1 written as cnt+1 >= live so a live of 0 cannot underflow;
  // '>=' also catches the case where live just dropped below the count.
  assign stepDue   = ({1'b0, stepCnt} + 33'd1) >= live;
  assign phaseLoad = host.iLatchPhaseUpdate && (host.iPhaseUpdate < 3'(pPhaseCount));

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      stepCnt   <= '0;
      phase     <= '0;
      phaseStep <= 1'b0;
    end else begin
      phaseStep <= 1'b0;
      if (phaseLoad) begin
        // Override beats a coincident step boundary.
        phase   <= host.iPhaseUpdate;
        stepCnt <= '0;
      end else if (!running) begin
        stepCnt <= '0;
      end else if (stepDue) begin
        stepCnt   <= '0;
        phase     <= (phase == cLastPhase) ? 3'd0 : phase + 3'd1;
        phaseStep <= 1'b1;
      end else begin
        stepCnt <= stepCnt + 1'b1;
      end
    end
  end

  // ---- status (registered from current state/live) ----
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      stop          <= 1'b1;
      freqReflected <= 1'b1;
    end else begin
      stop          <= (state == IDLE);
      freqReflected <= ((state == RUN) && (live == {1'b0, freqTarget})) ||
                       ((state == IDLE) && (freqTarget == '0));
    end
  end

  assign host.oFreqTarget    = freqTarget;
  assign host.oPhase         = phase;
  assign host.oPhaseStep     = phaseStep;
  assign host.oFreqReflected = freqReflected;
  assign host.oStop          = stop;

endmodule

// File: tb/tb_mbldcm_commutation_ctrl.sv
// Self-checking bench for mbldcm_commutation_ctrl with
// pStartPeriod=1000, pMinPeriod=10, pRampStep=100, pRampDiv=4.
module tb_mbldcm_commutation_ctrl;
  import mbldcm_pkg::*;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  mbldcm_commutation_ctrl_if host();

  mbldcm_commutation_ctrl #(
    .pStartPeriod(32'd1000),
    .pMinPeriod  (32'd10),
    .pRampStep   (32'd100),
    .pRampDiv    (16'd4)
  ) dut (
    .iClock  (clk),
    .iReset_n(rstN),
    .host    (host)
  );

  int errCnt = 0;
  int chkCnt = 0;
  int expPh  = 0;
  int nPulse = 0;
  logic [31:0] tgtQ[$];
  int          phQ[$];

  // One clock; advance the phase model on every observed step pulse.
  task automatic tick();
    @(negedge clk);
    if (host.oPhaseStep === 1'b1) begin
      expPh = (expPh + 1) % 6;
      nPulse++;
    end
  endtask

  // Strobe a target write and queue the clamped value it should read back as.
  task automatic driveTarget(input logic [31:0] v);
    logic [31:0] e;
    e = (v == 0) ? 32'd0 : (v < 10) ? 32'd10 : (v > 1000) ? 32'd1000 : v;
    tgtQ.push_back(e);
    host.iFreqTarget      = v;
    host.iLatchFreqTarget = 1'b1;
    tick();
    host.iLatchFreqTarget = 1'b0;
  endtask

  // Clocks until the next step pulse, or -1 if none within bound.
  task automatic waitStep(input int bound, output int n);
    int p0;
    p0 = nPulse;
    n  = 0;
    do begin tick(); n++; end while (nPulse == p0 && n < bound);
    if (nPulse == p0) n = -1;
  endtask

  task automatic test_reset();
    int p0;
    host.iFreqTarget = '0; host.iLatchFreqTarget = 1'b0;
    host.iPhaseUpdate = '0; host.iLatchPhaseUpdate = 1'b0; host.iEnable = 1'b0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    chkCnt++; if (host.oFreqTarget !== 32'd0) begin errCnt++; $display("FAIL rst_tgt: got %0d want 0", host.oFreqTarget); end
    chkCnt++; if (host.oPhase !== 3'd0) begin errCnt++; $display("FAIL rst_phase: got %0d want 0", host.oPhase); end
    chkCnt++; if (host.oPhaseStep !== 1'b0) begin errCnt++; $display("FAIL rst_step: got %b want 0", host.oPhaseStep); end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL rst_refl: got %b want 1", host.oFreqReflected); end
    chkCnt++; if (host.oStop !== 1'b1) begin errCnt++; $display("FAIL rst_stop: got %b want 1", host.oStop); end
    rstN = 1'b1;
    host.iEnable = 1'b1;
    p0 = nPulse;
    repeat (5000) tick();
    chkCnt++; if (nPulse != p0) begin errCnt++; $display("FAIL idle_pulses: got %0d want 0", nPulse - p0); end
    chkCnt++; if (host.oStop !== 1'b1) begin errCnt++; $display("FAIL idle_stop: got %b want 1", host.oStop); end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL idle_refl: got %b want 1", host.oFreqReflected); end
    chkCnt++; if (host.oPhase !== 3'd0) begin errCnt++; $display("FAIL idle_phase: got %0d want 0", host.oPhase); end
  endtask

  task automatic test_spin_up();
    logic [31:0] e;
    int n, ph;
    driveTarget(32'd500);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL spin_tgt: got %0d want %0d", host.oFreqTarget, e); end
    repeat (4) tick();
    chkCnt++; if (host.oStop !== 1'b0) begin errCnt++; $display("FAIL spin_stop: got %b want 0", host.oStop); end
    chkCnt++; if (host.oFreqReflected !== 1'b0) begin errCnt++; $display("FAIL spin_refl_early: got %b want 0", host.oFreqReflected); end
    n = 0;
    while (host.oFreqReflected !== 1'b1 && n < 100) begin tick(); n++; end
    chkCnt++; if (host.oFreqReflected !== 1'b1 || n > 25) begin errCnt++; $display("FAIL spin_refl: refl=%b after %0d clocks want 1 within 25", host.oFreqReflected, n); end
    for (int i = 1; i <= 6; i++) phQ.push_back(i % 6);
    for (int i = 0; i < 6; i++) begin
      waitStep(600, n);
      ph = phQ.pop_front();
      chkCnt++; if (host.oPhase !== 3'(ph)) begin errCnt++; $display("FAIL spin_phase%0d: got %0d want %0d", i, host.oPhase, ph); end
      if (i > 0) begin
        chkCnt++; if (n != 500) begin errCnt++; $display("FAIL spin_interval%0d: got %0d want 500", i, n); end
      end
    end
    tick();
    chkCnt++; if (host.oPhaseStep !== 1'b0) begin errCnt++; $display("FAIL spin_pulse_width: got %b want 0", host.oPhaseStep); end
  endtask

  task automatic test_clamp_stop();
    logic [31:0] e;
    int n, p0;
    driveTarget(32'd5);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL clamp_low: got %0d want %0d", host.oFreqTarget, e); end
    driveTarget(32'd2000);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL clamp_high: got %0d want %0d", host.oFreqTarget, e); end
    driveTarget(32'd500);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL clamp_mid: got %0d want %0d", host.oFreqTarget, e); end
    n = 0;
    while (host.oFreqReflected !== 1'b1 && n < 200) begin tick(); n++; end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL clamp_refl: got %b want 1", host.oFreqReflected); end
    driveTarget(32'd0);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL stop_tgt: got %0d want %0d", host.oFreqTarget, e); end
    repeat (3) tick();
    chkCnt++; if (host.oStop !== 1'b0) begin errCnt++; $display("FAIL stopping_stop: got %b want 0", host.oStop); end
    n = 0;
    while (host.oStop !== 1'b1 && n < 200) begin tick(); n++; end
    chkCnt++; if (host.oStop !== 1'b1 || n > 40) begin errCnt++; $display("FAIL stop_reached: stop=%b after %0d clocks want 1 within 40", host.oStop, n); end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL stop_refl: got %b want 1", host.oFreqReflected); end
    p0 = nPulse;
    repeat (2000) tick();
    chkCnt++; if (nPulse != p0) begin errCnt++; $display("FAIL stop_pulses: got %0d want 0", nPulse - p0); end
    chkCnt++; if (host.oPhase !== 3'(expPh)) begin errCnt++; $display("FAIL stop_phase_hold: got %0d want %0d", host.oPhase, expPh); end
  endtask

  task automatic test_phase_override();
    logic [31:0] e;
    int n, ph;
    driveTarget(32'd500);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL ovr_tgt: got %0d want %0d", host.oFreqTarget, e); end
    waitStep(1200, n);
    chkCnt++; if (n < 0) begin errCnt++; $display("FAIL ovr_first_step: got timeout want pulse"); end
    waitStep(600, n);
    chkCnt++; if (n != 500) begin errCnt++; $display("FAIL ovr_period: got %0d want 500", n); end
    // Next step boundary is 500 edges after the pulse just seen.
    repeat (499) tick();
    host.iPhaseUpdate = 3'd3; host.iLatchPhaseUpdate = 1'b1;
    phQ.push_back(3); expPh = 3;
    tick();
    host.iLatchPhaseUpdate = 1'b0;
    ph = phQ.pop_front();
    chkCnt++; if (host.oPhase !== 3'(ph)) begin errCnt++; $display("FAIL ovr_boundary_phase: got %0d want %0d", host.oPhase, ph); end
    chkCnt++; if (host.oPhaseStep !== 1'b0) begin errCnt++; $display("FAIL ovr_boundary_step: got %b want 0", host.oPhaseStep); end
    waitStep(600, n);
    chkCnt++; if (n != 500) begin errCnt++; $display("FAIL ovr_next_step: got %0d want 500", n); end
    chkCnt++; if (host.oPhase !== 3'd4) begin errCnt++; $display("FAIL ovr_after_phase: got %0d want 4", host.oPhase); end
    repeat (100) tick();
    host.iPhaseUpdate = 3'd1; host.iLatchPhaseUpdate = 1'b1;
    phQ.push_back(1); expPh = 1;
    tick();
    host.iLatchPhaseUpdate = 1'b0;
    ph = phQ.pop_front();
    chkCnt++; if (host.oPhase !== 3'(ph)) begin errCnt++; $display("FAIL ovr_mid_phase: got %0d want %0d", host.oPhase, ph); end
    waitStep(600, n);
    chkCnt++; if (n != 500) begin errCnt++; $display("FAIL ovr_mid_restart: got %0d want 500", n); end
    chkCnt++; if (host.oPhase !== 3'd2) begin errCnt++; $display("FAIL ovr_mid_next: got %0d want 2", host.oPhase); end
    repeat (50) tick();
    host.iPhaseUpdate = 3'd7; host.iLatchPhaseUpdate = 1'b1;
    tick();
    host.iLatchPhaseUpdate = 1'b0;
    chkCnt++; if (host.oPhase !== 3'(expPh)) begin errCnt++; $display("FAIL ovr_invalid: got %0d want %0d", host.oPhase, expPh); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] e;
    int n;
    driveTarget(32'd200);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL en_tgt: got %0d want %0d", host.oFreqTarget, e); end
    repeat (5) tick();
    host.iEnable = 1'b0;
    tick(); tick();
    chkCnt++; if (host.oStop !== 1'b1) begin errCnt++; $display("FAIL en_stop: got %b want 1", host.oStop); end
    chkCnt++; if (host.oFreqReflected !== 1'b0) begin errCnt++; $display("FAIL en_refl: got %b want 0", host.oFreqReflected); end
    waitStep(1000, n);
    chkCnt++; if (n != -1) begin errCnt++; $display("FAIL en_no_step: got pulse after %0d want none", n); end
    chkCnt++; if (host.oPhase !== 3'(expPh)) begin errCnt++; $display("FAIL en_phase_hold: got %0d want %0d", host.oPhase, expPh); end
    driveTarget(32'd1000);
    e = tgtQ.pop_front();
    chkCnt++; if (host.oFreqTarget !== e) begin errCnt++; $display("FAIL en_tgt2: got %0d want %0d", host.oFreqTarget, e); end
    // Restart loads live=1000 with a cleared counter: first step 1000 clocks after RUN entry.
    host.iEnable = 1'b1;
    waitStep(1200, n);
    chkCnt++; if (n != 1001) begin errCnt++; $display("FAIL en_restart: got %0d want 1001", n); end
    chkCnt++; if (host.oPhase !== 3'(expPh)) begin errCnt++; $display("FAIL en_restart_phase: got %0d want %0d", host.oPhase, expPh); end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL en_restart_refl: got %b want 1", host.oFreqReflected); end
  endtask

  task automatic test_async_reset();
    // Called at the negedge showing a step pulse; reset lands mid-cycle.
    #2 rstN = 1'b0;
    #1;
    chkCnt++; if (host.oFreqTarget !== 32'd0) begin errCnt++; $display("FAIL arst_tgt: got %0d want 0", host.oFreqTarget); end
    chkCnt++; if (host.oPhase !== 3'd0) begin errCnt++; $display("FAIL arst_phase: got %0d want 0", host.oPhase); end
    chkCnt++; if (host.oPhaseStep !== 1'b0) begin errCnt++; $display("FAIL arst_step: got %b want 0", host.oPhaseStep); end
    chkCnt++; if (host.oFreqReflected !== 1'b1) begin errCnt++; $display("FAIL arst_refl: got %b want 1", host.oFreqReflected); end
    chkCnt++; if (host.oStop !== 1'b1) begin errCnt++; $display("FAIL arst_stop: got %b want 1", host.oStop); end
    expPh = 0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) tick();
    chkCnt++; if (host.oStop !== 1'b1) begin errCnt++; $display("FAIL arst_release_stop: got %b want 1", host.oStop); end
  endtask

  initial begin
    test_reset();
    test_spin_up();
    test_clamp_stop();
    test_phase_override();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
